// File: rtl/cprv_decode_stage.sv
// cprv RV64 ID stage: decode, regfile read, hazard stall and registered payload to EX.
// Define CPRV_ID_FWD_EN to enable EX/MEM operand forwarding with load-use-only stalls.
module cprv_decode_stage #(
    parameter int XLEN        = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_id_i,
    output logic                   ready_id_o,
    input  logic [INSTR_WIDTH-1:0] instr_data_id_i,
    input  logic [PC_WIDTH-1:0]    pc_id_i,
    input  logic                   flush_i,
    output logic [4:0]             rs1_addr_rf_o,
    output logic [4:0]             rs2_addr_rf_o,
    input  logic [XLEN-1:0]        rs1_data_rf_i,
    input  logic [XLEN-1:0]        rs2_data_rf_i,
    input  logic                   ex_fwd_valid_i,
    input  logic                   ex_fwd_is_load_i,
    input  logic [4:0]             ex_fwd_addr_i,
    input  logic [XLEN-1:0]        ex_fwd_data_i,
    input  logic                   mem_fwd_valid_i,
    input  logic [4:0]             mem_fwd_addr_i,
    input  logic [XLEN-1:0]        mem_fwd_data_i,
    output logic                   valid_ex_o,
    input  logic                   ready_ex_i,
    output logic [PC_WIDTH-1:0]    pc_ex_o,
    output logic [XLEN-1:0]        rs1_data_ex_o,
    output logic [XLEN-1:0]        rs2_data_ex_o,
    output logic [4:0]             rd_addr_ex_o,
    output logic                   rd_en_ex_o,
    output logic [XLEN-1:0]        imm_data_ex_o,
    output logic [6:0]             opcode_ex_o,
    output logic [2:0]             funct3_ex_o,
    output logic [6:0]             funct7_ex_o,
    output logic                   mem_r_en_ex_o,
    output logic                   mem_w_en_ex_o,
    output logic                   branch_ex_o,
    output logic                   illegal_ex_o
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_OP_32  = 7'b0111011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [XLEN-1:0]     rs1_data;
        logic [XLEN-1:0]     rs2_data;
        logic [4:0]          rd_addr;
        logic                rd_en;
        logic [XLEN-1:0]     imm;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic                mem_r_en;
        logic                mem_w_en;
        logic                branch;
        logic                illegal;
    } payload_t;

    logic [31:0]     instr;
    logic [4:0]      rs1, rs2;
    logic            rs1_used, rs2_used;
    logic            stall, cke, accept;
    logic            hit_ex, hit_mem;
    logic [XLEN-1:0] op1, op2;
    payload_t        dec;
    payload_t        payload_d, payload_q;
    logic            valid_ex_d, valid_ex_q;

    assign instr         = instr_data_id_i[31:0];
    assign rs1           = instr[19:15];
    assign rs2           = instr[24:20];
    assign rs1_addr_rf_o = rs1;
    assign rs2_addr_rf_o = rs2;

    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        dec          = '0;
        dec.pc       = pc_id_i;
        dec.opcode   = instr[6:0];
        dec.funct3   = instr[14:12];
        dec.funct7   = instr[31:25];
        dec.rd_addr  = instr[11:7];
        dec.rs1_data = op1;
        dec.rs2_data = op2;
        case (instr[6:0])
            OP_OP, OP_OP_32: begin
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
                dec.rd_en = 1'b1;
            end
            OP_IMM, OP_IMM_32: begin
                rs1_used  = 1'b1;
                dec.rd_en = 1'b1;
                dec.imm   = {{(XLEN-12){instr[31]}}, instr[31:20]};
            end
            OP_LOAD: begin
                rs1_used     = 1'b1;
                dec.rd_en    = 1'b1;
                dec.mem_r_en = 1'b1;
                dec.imm      = {{(XLEN-12){instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
                dec.mem_w_en = 1'b1;
                dec.imm      = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
                dec.branch = 1'b1;
                dec.imm    = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
            end
            OP_JALR: begin
                rs1_used   = 1'b1;
                dec.rd_en  = 1'b1;
                dec.branch = 1'b1;
                dec.imm    = {{(XLEN-12){instr[31]}}, instr[31:20]};
            end
            OP_JAL: begin
                dec.rd_en  = 1'b1;
                dec.branch = 1'b1;
                dec.imm    = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                              instr[20], instr[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec.rd_en = 1'b1;
                dec.imm   = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
            end
            OP_FENCE, OP_SYSTEM: begin
                dec.imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            end
            default: dec.illegal = 1'b1;
        endcase
        if (instr[11:7] == 5'd0) dec.rd_en = 1'b0;
    end

    assign hit_ex  = ex_fwd_valid_i & (ex_fwd_addr_i != 5'd0) &
                     ((rs1_used & (rs1 == ex_fwd_addr_i)) | (rs2_used & (rs2 == ex_fwd_addr_i)));
    assign hit_mem = mem_fwd_valid_i & (mem_fwd_addr_i != 5'd0) &
                     ((rs1_used & (rs1 == mem_fwd_addr_i)) | (rs2_used & (rs2 == mem_fwd_addr_i)));

`ifdef CPRV_ID_FWD_EN
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf,
        input logic            ex_v,
        input logic [4:0]      ex_a,
        input logic [XLEN-1:0] ex_d,
        input logic            mem_v,
        input logic [4:0]      mem_a,
        input logic [XLEN-1:0] mem_d
    );
        if (rs == 5'd0)                    return '0;
        else if (ex_v && (ex_a == rs))     return ex_d;
        else if (mem_v && (mem_a == rs))   return mem_d;
        else                               return rf;
    endfunction

    assign op1 = fwd_sel(rs1, rs1_data_rf_i, ex_fwd_valid_i, ex_fwd_addr_i, ex_fwd_data_i,
                         mem_fwd_valid_i, mem_fwd_addr_i, mem_fwd_data_i);
    assign op2 = fwd_sel(rs2, rs2_data_rf_i, ex_fwd_valid_i, ex_fwd_addr_i, ex_fwd_data_i,
                         mem_fwd_valid_i, mem_fwd_addr_i, mem_fwd_data_i);
    // A load result is not ready in EX, so only that case stalls.
    assign stall = valid_id_i & hit_ex & ex_fwd_is_load_i;
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_fwd_is_load_i, ex_fwd_data_i, mem_fwd_data_i};
    assign op1   = (rs1 == 5'd0) ? '0 : rs1_data_rf_i;
    assign op2   = (rs2 == 5'd0) ? '0 : rs2_data_rf_i;
    // Without bypass paths, wait until every pending producer has retired to the regfile.
    assign stall = valid_id_i & (hit_ex | hit_mem);
`endif

    assign cke        = ~valid_ex_q | ready_ex_i;
    assign ready_id_o = flush_i | (cke & ~stall);
    assign accept     = valid_id_i & ready_id_o & ~flush_i;

    always_comb begin
        valid_ex_d = valid_ex_q;
        payload_d  = payload_q;
        if (flush_i)  valid_ex_d = 1'b0;
        else if (cke) valid_ex_d = valid_id_i & ~stall;
        if (accept)   payload_d  = dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_ex_q <= 1'b0;
            payload_q  <= '0;
        end else begin
            valid_ex_q <= valid_ex_d;
            payload_q  <= payload_d;
        end
    end

    assign valid_ex_o    = valid_ex_q;
    assign pc_ex_o       = payload_q.pc;
    assign rs1_data_ex_o = payload_q.rs1_data;
    assign rs2_data_ex_o = payload_q.rs2_data;
    assign rd_addr_ex_o  = payload_q.rd_addr;
    assign rd_en_ex_o    = payload_q.rd_en;
    assign imm_data_ex_o = payload_q.imm;
    assign opcode_ex_o   = payload_q.opcode;
    assign funct3_ex_o   = payload_q.funct3;
    assign funct7_ex_o   = payload_q.funct7;
    assign mem_r_en_ex_o = payload_q.mem_r_en;
    assign mem_w_en_ex_o = payload_q.mem_w_en;
    assign branch_ex_o   = payload_q.branch;
    assign illegal_ex_o  = payload_q.illegal;

endmodule

// File: tb/tb_cprv_decode_stage.sv
// Directed bench for cprv_decode_stage; checks decode, hazards, backpressure, flush and reset.
// Exercises the default build and, when CPRV_ID_FWD_EN is defined, the forwarding build.
module tb_cprv_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_id_i, ready_id_o, flush_i;
    logic [31:0] instr_data_id_i;
    logic [63:0] pc_id_i;
    logic [4:0]  rs1_addr_rf_o, rs2_addr_rf_o;
    logic [63:0] rs1_data_rf_i, rs2_data_rf_i;
    logic        ex_fwd_valid_i, ex_fwd_is_load_i;
    logic [4:0]  ex_fwd_addr_i;
    logic [63:0] ex_fwd_data_i;
    logic        mem_fwd_valid_i;
    logic [4:0]  mem_fwd_addr_i;
    logic [63:0] mem_fwd_data_i;
    logic        valid_ex_o, ready_ex_i;
    logic [63:0] pc_ex_o, rs1_data_ex_o, rs2_data_ex_o, imm_data_ex_o;
    logic [4:0]  rd_addr_ex_o;
    logic        rd_en_ex_o;
    logic [6:0]  opcode_ex_o, funct7_ex_o;
    logic [2:0]  funct3_ex_o;
    logic        mem_r_en_ex_o, mem_w_en_ex_o, branch_ex_o, illegal_ex_o;

    int n_assert = 0;
    int n_fail   = 0;

    cprv_decode_stage dut (
        .clk(clk), .rst(rst),
        .valid_id_i(valid_id_i), .ready_id_o(ready_id_o),
        .instr_data_id_i(instr_data_id_i), .pc_id_i(pc_id_i), .flush_i(flush_i),
        .rs1_addr_rf_o(rs1_addr_rf_o), .rs2_addr_rf_o(rs2_addr_rf_o),
        .rs1_data_rf_i(rs1_data_rf_i), .rs2_data_rf_i(rs2_data_rf_i),
        .ex_fwd_valid_i(ex_fwd_valid_i), .ex_fwd_is_load_i(ex_fwd_is_load_i),
        .ex_fwd_addr_i(ex_fwd_addr_i), .ex_fwd_data_i(ex_fwd_data_i),
        .mem_fwd_valid_i(mem_fwd_valid_i), .mem_fwd_addr_i(mem_fwd_addr_i),
        .mem_fwd_data_i(mem_fwd_data_i),
        .valid_ex_o(valid_ex_o), .ready_ex_i(ready_ex_i), .pc_ex_o(pc_ex_o),
        .rs1_data_ex_o(rs1_data_ex_o), .rs2_data_ex_o(rs2_data_ex_o),
        .rd_addr_ex_o(rd_addr_ex_o), .rd_en_ex_o(rd_en_ex_o),
        .imm_data_ex_o(imm_data_ex_o), .opcode_ex_o(opcode_ex_o),
        .funct3_ex_o(funct3_ex_o), .funct7_ex_o(funct7_ex_o),
        .mem_r_en_ex_o(mem_r_en_ex_o), .mem_w_en_ex_o(mem_w_en_ex_o),
        .branch_ex_o(branch_ex_o), .illegal_ex_o(illegal_ex_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [63:0] pc);
        valid_id_i      = 1'b1;
        instr_data_id_i = ins;
        pc_id_i         = pc;
    endtask

    initial begin
        rst = 1'b1;
        valid_id_i = 1'b0; flush_i = 1'b0; instr_data_id_i = '0; pc_id_i = '0;
        rs1_data_rf_i = '0; rs2_data_rf_i = '0;
        ex_fwd_valid_i = 1'b0; ex_fwd_is_load_i = 1'b0; ex_fwd_addr_i = '0; ex_fwd_data_i = '0;
        mem_fwd_valid_i = 1'b0; mem_fwd_addr_i = '0; mem_fwd_data_i = '0;
        ready_ex_i = 1'b1;
        tick(); tick();

        chk("rst_valid", valid_ex_o, 0);
        chk("rst_ready", ready_id_o, 1);
        chk("rst_pc", pc_ex_o, 0);
        chk("rst_imm", imm_data_ex_o, 0);
        chk("rst_rd_en", rd_en_ex_o, 0);
        chk("rst_illegal", illegal_ex_o, 0);
        rst = 1'b0;

        drive(32'hFFF00093, 64'h100);
        #1;
        chk("addi_rs1_addr", rs1_addr_rf_o, 0);
        chk("addi_ready", ready_id_o, 1);
        tick();
        chk("addi_valid", valid_ex_o, 1);
        chk("addi_pc", pc_ex_o, 64'h100);
        chk("addi_rd", rd_addr_ex_o, 1);
        chk("addi_rd_en", rd_en_ex_o, 1);
        chk("addi_imm", imm_data_ex_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_opcode", opcode_ex_o, 7'h13);

        drive(32'h0020A423, 64'h104);
        rs1_data_rf_i = 64'h1000; rs2_data_rf_i = 64'hABCD;
        #1;
        chk("sw_rs1_addr", rs1_addr_rf_o, 1);
        chk("sw_rs2_addr", rs2_addr_rf_o, 2);
        tick();
        chk("sw_mem_w", mem_w_en_ex_o, 1);
        chk("sw_mem_r", mem_r_en_ex_o, 0);
        chk("sw_rd_en", rd_en_ex_o, 0);
        chk("sw_imm", imm_data_ex_o, 64'd8);
        chk("sw_funct3", funct3_ex_o, 3'd2);
        chk("sw_rs1_data", rs1_data_ex_o, 64'h1000);
        chk("sw_rs2_data", rs2_data_ex_o, 64'hABCD);

        drive(32'h800002B7, 64'h108);
        tick();
        chk("lui_imm", imm_data_ex_o, 64'hFFFF_FFFF_8000_0000);
        chk("lui_rd", rd_addr_ex_o, 5);
        chk("lui_rd_en", rd_en_ex_o, 1);

        drive(32'hFE000EE3, 64'h10C);
        tick();
        chk("beq_branch", branch_ex_o, 1);
        chk("beq_imm", imm_data_ex_o, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_rd_en", rd_en_ex_o, 0);

        drive(32'h00000013, 64'h110);
        tick();
        chk("addi_x0_rd_en", rd_en_ex_o, 0);
        chk("addi_x0_valid", valid_ex_o, 1);

        drive(32'h00000000, 64'h114);
        tick();
        chk("ill_flag", illegal_ex_o, 1);
        chk("ill_imm", imm_data_ex_o, 0);
        chk("ill_rd_en", rd_en_ex_o, 0);

        drive(32'h0100B303, 64'h118);
        tick();
        chk("ld_mem_r", mem_r_en_ex_o, 1);
        chk("ld_imm", imm_data_ex_o, 64'd16);
        chk("ld_illegal", illegal_ex_o, 0);

        drive(32'hFF9FF0EF, 64'h11C);
        tick();
        chk("jal_imm", imm_data_ex_o, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("jal_branch", branch_ex_o, 1);
        chk("jal_rd_en", rd_en_ex_o, 1);

        drive(32'h402081B3, 64'h120);
        tick();
        chk("sub_funct7", funct7_ex_o, 7'h20);
        chk("sub_imm", imm_data_ex_o, 0);
        chk("sub_rd", rd_addr_ex_o, 3);

        // Backpressure: EX holds, ID must not accept.
        ready_ex_i = 1'b0;
        drive(32'hFFF00093, 64'h200);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", ready_id_o, 0);
            tick();
            chk("bp_valid", valid_ex_o, 1);
            chk("bp_pc", pc_ex_o, 64'h120);
            chk("bp_rd", rd_addr_ex_o, 3);
            chk("bp_funct7", funct7_ex_o, 7'h20);
        end
        ready_ex_i = 1'b1;
        #1;
        chk("bp_release_ready", ready_id_o, 1);
        tick();
        chk("bp_release_pc", pc_ex_o, 64'h200);
        chk("bp_release_rd", rd_addr_ex_o, 1);

        ready_ex_i = 1'b0;
        drive(32'h0020A423, 64'h300);
        flush_i = 1'b1;
        #1;
        chk("flush_ready", ready_id_o, 1);
        tick();
        chk("flush_valid", valid_ex_o, 0);
        chk("flush_pc_held", pc_ex_o, 64'h200);
        flush_i = 1'b0;
        tick();
        chk("post_flush_valid", valid_ex_o, 1);
        chk("post_flush_pc", pc_ex_o, 64'h300);

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_valid", valid_ex_o, 0);
        chk("arst_pc", pc_ex_o, 0);
        chk("arst_imm", imm_data_ex_o, 0);
        chk("arst_mem_w", mem_w_en_ex_o, 0);
        @(negedge clk);
        rst = 1'b0;
        ready_ex_i = 1'b1;

        drive(32'h002081B3, 64'h400);
        rs1_data_rf_i = 64'h77; rs2_data_rf_i = 64'h22;
`ifdef CPRV_ID_FWD_EN
        ex_fwd_valid_i = 1'b1; ex_fwd_addr_i = 5'd1; ex_fwd_data_i = 64'h55;
        mem_fwd_valid_i = 1'b1; mem_fwd_addr_i = 5'd1; mem_fwd_data_i = 64'h66;
        #1;
        chk("fwd_ready", ready_id_o, 1);
        tick();
        chk("fwd_ex_rs1", rs1_data_ex_o, 64'h55);
        chk("fwd_rf_rs2", rs2_data_ex_o, 64'h22);
        ex_fwd_valid_i = 1'b0;
        tick();
        chk("fwd_mem_rs1", rs1_data_ex_o, 64'h66);
        drive(32'h002001B3, 64'h404);
        ex_fwd_valid_i = 1'b1; ex_fwd_addr_i = 5'd0;
        tick();
        chk("fwd_x0_rs1", rs1_data_ex_o, 0);
        mem_fwd_valid_i = 1'b0;
        drive(32'h002081B3, 64'h408);
        ex_fwd_addr_i = 5'd1; ex_fwd_is_load_i = 1'b1;
        #1;
        chk("lu_ready", ready_id_o, 0);
        tick();
        chk("lu_bubble", valid_ex_o, 0);
        ex_fwd_is_load_i = 1'b0;
        #1;
        chk("lu_release_ready", ready_id_o, 1);
        tick();
        chk("lu_issue_valid", valid_ex_o, 1);
        chk("lu_issue_pc", pc_ex_o, 64'h408);
        chk("lu_issue_rs1", rs1_data_ex_o, 64'h55);
`else
        mem_fwd_valid_i = 1'b1; mem_fwd_addr_i = 5'd2; mem_fwd_data_i = 64'h66;
        #1;
        chk("mem_stall_ready", ready_id_o, 0);
        tick();
        chk("mem_stall_bubble", valid_ex_o, 0);
        tick();
        chk("mem_stall_bubble2", valid_ex_o, 0);
        chk("mem_stall_ready2", ready_id_o, 0);
        mem_fwd_valid_i = 1'b0;
        #1;
        chk("mem_release_ready", ready_id_o, 1);
        tick();
        chk("mem_issue_valid", valid_ex_o, 1);
        chk("mem_issue_pc", pc_ex_o, 64'h400);
        chk("mem_issue_rs2", rs2_data_ex_o, 64'h22);
        chk("mem_issue_rs1", rs1_data_ex_o, 64'h77);
        drive(32'h002081B3, 64'h404);
        ex_fwd_valid_i = 1'b1; ex_fwd_is_load_i = 1'b0; ex_fwd_addr_i = 5'd1;
        #1;
        chk("ex_nonload_stall", ready_id_o, 0);
        tick();
        chk("ex_nonload_bubble", valid_ex_o, 0);
        ex_fwd_valid_i = 1'b0;
        tick();
        chk("ex_release_valid", valid_ex_o, 1);
        chk("ex_release_pc", pc_ex_o, 64'h404);
`endif
        valid_id_i = 1'b0;
        tick();
        chk("idle_valid", valid_ex_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cprv_decode_stage.md
Name: cprv_decode_stage

Overview:
Parametrised successor ID stage for the cprv RV64 pipeline. Decodes all RV64I formats (R/I/S/B/U/J), reads the register file, and forwards in-flight results from EX/MEM. Detects load-use hazards and inserts bubbles. Drives a valid/ready-registered payload to EX, with flush support.

Parameters:
XLEN, 64, datapath and immediate width.
INSTR_WIDTH, 32, instruction width.
PC_WIDTH, 64, program counter width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
valid_id_i  in  1  instruction valid from IF
ready_id_o  out  1  ID accepts instruction
instr_data_id_i  in  INSTR_WIDTH  instruction
pc_id_i  in  PC_WIDTH  instruction PC
flush_i  in  1  kill ID/EX contents
rs1_addr_rf_o, rs2_addr_rf_o  out  5  regfile read addresses (instr[19:15], instr[24:20], combinational)
rs1_data_rf_i, rs2_data_rf_i  in  XLEN  regfile read data (write-through of WB assumed)
ex_fwd_valid_i  in  1  EX holds a pending write
ex_fwd_is_load_i  in  1  EX write comes from a LOAD
ex_fwd_addr_i  in  5  EX rd
ex_fwd_data_i  in  XLEN  EX result
mem_fwd_valid_i  in  1  MEM holds a pending write
mem_fwd_addr_i  in  5  MEM rd
mem_fwd_data_i  in  XLEN  MEM result
valid_ex_o  out  1  payload valid to EX
ready_ex_i  in  1  EX accepts
pc_ex_o  out  PC_WIDTH  PC
rs1_data_ex_o, rs2_data_ex_o  out  XLEN  operands
rd_addr_ex_o  out  5  destination
rd_en_ex_o  out  1  register write enable
imm_data_ex_o  out  XLEN  sign-extended immediate
opcode_ex_o  out  7; funct3_ex_o  out  3; funct7_ex_o  out  7
mem_r_en_ex_o, mem_w_en_ex_o  out  1  LOAD / STORE
branch_ex_o  out  1  BRANCH, JAL or JALR
illegal_ex_o  out  1  unknown opcode or instr[1:0] != 2'b11

Behaviour:
- Reset (async, rst=1): all registered outputs are 0; ready_id_o follows the combinational rules below with valid_ex_o=0.
- cke = ~valid_ex_o | ready_ex_i; ready_id_o = cke & ~stall; accept = valid_id_i & ready_id_o.
- On cke with no flush: valid_ex_o <= valid_id_i & ~stall. Payload registers load on accept. During a stall, a bubble (valid_ex_o=0) is issued and the ID instruction is held.
- When cke=0, all EX outputs hold their values.
- flush_i has priority over everything: valid_ex_o <= 0 next edge regardless of cke, ready_id_o=1, and the input is discarded.
- Latency: 1 cycle from accept to valid_ex_o.
- rs1 used by OP, OP_IMM, OP_32, OP_IMM_32, LOAD, STORE, BRANCH, JALR. rs2 used by OP, OP_32, STORE, BRANCH.
- rd_en = 1 for OP, OP_IMM, OP_32, OP_IMM_32, LOAD, LUI, AUIPC, JAL, JALR, and forced to 0 when rd==0.
- Immediates are sign-extended from bit 31 to XLEN:
  - I: instr[31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R-type and illegal: 0.
- Operand forwarding priority: EX > MEM > regfile. A match requires the source valid, addr==rs, and rs!=0. x0 always reads 0.
- stall = valid_id_i & ex_fwd_valid_i & ex_fwd_is_load_i & (ex_fwd_addr_i!=0) & addr matches a used rs.
- illegal_ex_o is flagged only; it has no pipeline effect.

Optional Feature:
- Macro: CPRV_ID_FWD_EN.
- Defined: forwarding and load-use stall exactly as above.
- Undefined: forwarding muxes are removed and operands come only from the regfile. stall asserts on any valid EX or MEM pending write whose nonzero addr matches a used rs, regardless of ex_fwd_is_load_i.

Test Plan:
- Decode and immediates: 0xFFF00093 (addi x1,x0,-1) -> rd_addr=1, rd_en=1, imm=0xFFFF_FFFF_FFFF_FFFF. 0x0020A423 (sw x2,8(x1)) -> mem_w_en=1, rd_en=0, imm=8. 0x800002B7 (lui x5) -> imm=0xFFFF_FFFF_8000_0000. 0xFE000EE3 (beq) -> branch=1, imm=-4.
- Forwarding (FWD_EN): add x3,x1,x2 (0x002081B3) with EX addr1 data 0x55, MEM addr1 data 0x66, regfile 0x77 -> rs1_data_ex_o=0x55. With only MEM valid -> 0x66. With rs=x0 -> 0.
- Load-use: same add with ex_fwd_valid=1, is_load=1, addr=1 -> ready_id_o=0 for 1 cycle, one bubble, then the instruction issues once is_load drops.
- Backpressure: valid_ex_o=1, ready_ex_i=0 for 3 cycles -> ready_id_o=0 and all EX outputs stable; released on ready_ex_i=1.
- Flush/reset: flush_i=1 with valid_ex_o=1 and ready_ex_i=0 -> valid_ex_o=0 next edge. rst pulsed mid-stream -> all outputs 0 immediately (asynchronous).
- FWD_EN undefined: MEM pending write to x2 plus instruction reading x2 -> stall until mem_fwd_valid_i drops; operand then taken from regfile.
